// File: rtl/pic_host_bus_master_if.sv
// Host-side handshake and 8259 pin bundle for pic_host_bus_master.
// The shared data bus is resolved here so the master itself never drives Z.
interface pic_host_bus_master_if;
    logic       init_go;
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic       init_done;
    logic       init_busy;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic       cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       intr;
    logic       int_en;
    logic       vec_valid;
    logic [7:0] vec;
    logic       busy;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       inta_n;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] pic_d;
    logic       pic_oe;
    wire  [7:0] d;

    assign d = d_oe ? d_out : (pic_oe ? pic_d : 8'hzz);

    modport master (
        input  init_go, icw1, icw2, icw3, icw4, cmd_valid, cmd_rd, cmd_a0, cmd_data,
               intr, int_en, d,
        output init_done, init_busy, cmd_ready, rsp_valid, rsp_data, vec_valid, vec, busy,
               cs_n, wr_n, rd_n, inta_n, a0, d_out, d_oe
    );

    modport slave (
        output init_go, icw1, icw2, icw3, icw4, cmd_valid, cmd_rd, cmd_a0, cmd_data,
               intr, int_en, pic_d, pic_oe,
        input  init_done, init_busy, cmd_ready, rsp_valid, rsp_data, vec_valid, vec, busy,
               cs_n, wr_n, rd_n, inta_n, a0, d
    );
endinterface

// File: rtl/pic_host_bus_master.sv
// CPU-side 8259 bus master: ICW init sequence, single OCW writes / status reads,
// and the two-pulse INTA cycle with vector capture.
module pic_host_bus_master #(
    parameter int unsigned StrobeCycles = 2,
    parameter int unsigned GapCycles    = 2
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pic_host_bus_master_if.master bus
);
    localparam int unsigned CntMax = (StrobeCycles > GapCycles) ? StrobeCycles : GapCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
    localparam logic [CntW-1:0] GapLoad    = CntW'(GapCycles - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StAck1, StGap, StAck2} state_e;
    typedef enum logic [2:0] {SeqIcw1, SeqIcw2, SeqIcw3, SeqIcw4, SeqCmd} seq_e;

    state_e          state_q, state_d;
    seq_e            seq_q, seq_d, next_icw;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    logic            int_meta_q, int_sync_q;
    logic            rearm_q, rearm_d;
    logic            cmd_rd_q, cmd_rd_d, cmd_a0_q, cmd_a0_d;
    logic [7:0]      cmd_data_q, cmd_data_d;
    logic            rsp_valid_q, rsp_valid_d, vec_valid_q, vec_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d, vec_q, vec_d;
    logic            ack_req, more_icw, in_bus, cur_rd, cur_a0;
    logic [7:0]      cur_data;

    assign ack_req = bus.int_en & int_sync_q & rearm_q & init_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            seq_q       <= SeqCmd;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            int_meta_q  <= 1'b0;
            int_sync_q  <= 1'b0;
            rearm_q     <= 1'b1;
            cmd_rd_q    <= 1'b0;
            cmd_a0_q    <= 1'b0;
            cmd_data_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            vec_valid_q <= 1'b0;
            vec_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            int_meta_q  <= bus.intr;
            int_sync_q  <= int_meta_q;
            rearm_q     <= rearm_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_a0_q    <= cmd_a0_d;
            cmd_data_q  <= cmd_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            vec_valid_q <= vec_valid_d;
            vec_q       <= vec_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        // Rearm only once the synchronized INT has been seen low again.
        rearm_d     = rearm_q | ~int_sync_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_a0_d    = cmd_a0_q;
        cmd_data_d  = cmd_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        vec_valid_d = 1'b0;
        vec_d       = vec_q;
        more_icw    = 1'b0;
        next_icw    = SeqIcw2;
        unique case (state_q)
            StIdle: begin
                if (bus.init_go) begin
                    init_done_d = 1'b0;
                    seq_d       = SeqIcw1;
                    state_d     = StSetup;
                end else if (ack_req) begin
                    rearm_d = 1'b0;
                    cnt_d   = StrobeLoad;
                    state_d = StAck1;
                end else if (bus.cmd_valid && init_done_q) begin
                    cmd_rd_d   = bus.cmd_rd;
                    cmd_a0_d   = bus.cmd_a0;
                    cmd_data_d = bus.cmd_data;
                    seq_d      = SeqCmd;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = StrobeLoad;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    if (cur_rd) begin
                        rsp_data_d  = bus.d;
                        rsp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                case (seq_q)
                    SeqIcw1: more_icw = 1'b1;
                    SeqIcw2: begin
                        more_icw = ~bus.icw1[1] | bus.icw1[0];
                        next_icw = bus.icw1[1] ? SeqIcw4 : SeqIcw3;
                    end
                    SeqIcw3: begin
                        more_icw = bus.icw1[0];
                        next_icw = SeqIcw4;
                    end
                    default: more_icw = 1'b0;
                endcase
                if (more_icw) begin
                    seq_d   = next_icw;
                    state_d = StSetup;
                end else begin
                    state_d = StIdle;
                    if (seq_q != SeqCmd) init_done_d = 1'b1;
                end
            end
            StAck1: begin
                if (cnt_q == '0) begin
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    cnt_d   = StrobeLoad;
                    state_d = StAck2;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAck2: begin
                if (cnt_q == '0) begin
                    vec_d       = bus.d;
                    vec_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur_rd   = 1'b0;
        cur_a0   = 1'b1;
        cur_data = 8'h00;
        case (seq_q)
            SeqIcw1: begin
                cur_a0   = 1'b0;
                cur_data = bus.icw1;
            end
            SeqIcw2: cur_data = bus.icw2;
            SeqIcw3: cur_data = bus.icw3;
            SeqIcw4: cur_data = bus.icw4;
            default: begin
                cur_rd   = cmd_rd_q;
                cur_a0   = cmd_a0_q;
                cur_data = cmd_data_q;
            end
        endcase
    end

    assign in_bus        = (state_q == StSetup) | (state_q == StStrobe) | (state_q == StHold);
    assign bus.cs_n      = ~in_bus;
    assign bus.wr_n      = ~((state_q == StStrobe) & ~cur_rd);
    assign bus.rd_n      = ~((state_q == StStrobe) & cur_rd);
    assign bus.inta_n    = ~((state_q == StAck1) | (state_q == StAck2));
    assign bus.a0        = in_bus & cur_a0;
    assign bus.d_oe      = in_bus & ~cur_rd;
    assign bus.d_out     = cur_data;
    assign bus.init_done = init_done_q;
    assign bus.init_busy = (state_q != StIdle) & (seq_q != SeqCmd);
    assign bus.busy      = state_q != StIdle;
    assign bus.cmd_ready = (state_q == StIdle) & init_done_q & ~ack_req & ~bus.init_go;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec       = vec_q;
endmodule
